// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes from the ALU control decoder,
// execute-unit FSM states and the shift kinds used by the iterative shifter.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SUB  = 4'b0110,
    ALU_SRL  = 4'b1000,
    ALU_SLL  = 4'b1001,
    ALU_SRA  = 4'b1010,
    ALU_SLT  = 4'b1100,
    ALU_SLTU = 4'b1110
  } alu_op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } exec_state_e;

  typedef enum logic [1:0] {
    SH_SRL = 2'd0,
    SH_SLL = 2'd1,
    SH_SRA = 2'd2
  } shift_kind_e;

  function automatic logic is_shift_op(input logic [3:0] code);
    return (code == ALU_SRL) || (code == ALU_SLL) || (code == ALU_SRA);
  endfunction

  function automatic shift_kind_e shift_kind_of(input logic [3:0] code);
    case (code)
      ALU_SLL: return SH_SLL;
      ALU_SRA: return SH_SRA;
      default: return SH_SRL;
    endcase
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One combinational step of the iterative shifter: shifts value_i by at most
// SHIFT_STEP positions in the direction/fill selected by kind_i.
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SHIFT_STEP = 4,
  parameter int unsigned AMT_W      = $clog2(SHIFT_STEP + 1)
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic [AMT_W-1:0] amount_i,
  input  shift_kind_e      kind_i,
  output logic [WIDTH-1:0] value_o
);

  always_comb begin
    value_o = value_i;
    case (kind_i)
      SH_SLL:  value_o = value_i << amount_i;
      SH_SRA:  value_o = $unsigned($signed(value_i) >>> amount_i);
      default: value_o = value_i >> amount_i;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops land in the output register directly,
// shifts iterate SHIFT_STEP bits per cycle; valid/ready on both sides plus flush.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SHIFT_STEP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_inst,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned AW = $clog2(SHIFT_STEP + 1);

  exec_state_e      state_q;
  shift_kind_e      kind_q;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SW-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             out_valid_q;

  logic [WIDTH-1:0] alu_res;
  logic [SW-1:0]    shamt;
  logic [SW-1:0]    step;
  logic [AW-1:0]    step_amt;
  logic             accept;
  logic             drain;
  logic             shift_go;

  assign shamt    = op_b[SW-1:0];
  assign in_ready = !rst && (state_q == IDLE) && (!out_valid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid_q && out_ready;
  assign shift_go = is_shift_op(alu_inst) && (shamt != '0);

  always_comb begin
    alu_res = op_a + op_b;
    case (alu_inst)
      ALU_AND:  alu_res = op_a & op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, op_a < op_b};
      // Only reached with a zero shift amount; nonzero shifts go through SHIFT.
      ALU_SRL, ALU_SLL, ALU_SRA: alu_res = op_a;
      default:  alu_res = op_a + op_b;
    endcase
  end

  always_comb begin
    if (32'(rem_q) > SHIFT_STEP) step = SW'(SHIFT_STEP);
    else                         step = rem_q;
    rem_d    = rem_q - step;
    step_amt = AW'(step);
  end

  alu_shift_step #(
    .WIDTH      (WIDTH),
    .SHIFT_STEP (SHIFT_STEP),
    .AMT_W      (AW)
  ) u_shift_step (
    .value_i  (work_q),
    .amount_i (step_amt),
    .kind_i   (kind_q),
    .value_o  (work_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      kind_q      <= SH_SRL;
      work_q      <= '0;
      rem_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (shift_go) begin
              kind_q      <= shift_kind_of(alu_inst);
              work_q      <= op_a;
              rem_q       <= shamt;
              out_valid_q <= 1'b0;
              state_q     <= SHIFT;
            end else begin
              result_q    <= alu_res;
              zero_q      <= (alu_res == '0);
              out_valid_q <= 1'b1;
            end
          end else if (drain) begin
            out_valid_q <= 1'b0;
          end
        end
        SHIFT: begin
          work_q <= work_d;
          rem_q  <= rem_d;
          if (rem_d == '0) begin
            result_q    <= work_d;
            zero_q      <= (work_d == '0);
            out_valid_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with hand-computed expected values.
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   alu_inst;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;

  int ncmp  = 0;
  int nfail = 0;

  alu_exec_unit #(
    .WIDTH      (32),
    .SHIFT_STEP (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_inst  (alu_inst),
    .op_a      (op_a),
    .op_b      (op_b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    alu_inst = code;
    op_a     = a;
    op_b     = b;
  endtask

  // Single-cycle op: accepted at the coming edge, result visible after it.
  task automatic op1(input string tag, input logic [3:0] code, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
    drive(code, a, b);
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_vld"}, 32'(out_valid), 32'd1);
    check({tag, "_res"}, result, exp);
    check({tag, "_zero"}, 32'(zero), 32'(exp == 32'd0));
  endtask

  // Shift: count edges after the acceptance edge until out_valid rises.
  task automatic shop(input string tag, input logic [3:0] code, input logic [31:0] a,
                      input logic [31:0] b, input int exp_k, input logic [31:0] exp);
    int   cnt;
    logic saw_ready;
    drive(code, a, b);
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    cnt       = 0;
    saw_ready = 1'b0;
    while (!out_valid && cnt < 40) begin
      if (in_ready) saw_ready = 1'b1;
      @(negedge clk);
      cnt++;
    end
    check({tag, "_lat"}, 32'(cnt), 32'(exp_k));
    check({tag, "_blk"}, 32'(saw_ready), 32'd0);
    check({tag, "_res"}, result, exp);
    check({tag, "_zero"}, 32'(zero), 32'(exp == 32'd0));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    alu_inst  = 4'd0;
    op_a      = '0;
    op_b      = '0;

    #1;
    check("rst_vld", 32'(out_valid), 32'd0);
    check("rst_res", result, 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_rdy", 32'(in_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rdy_after_rst", 32'(in_ready), 32'd1);

    op1("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000);
    @(negedge clk);
    check("drain_clear", 32'(out_valid), 32'd0);

    op1("sub_zero", ALU_SUB, 32'd5, 32'd5, 32'd0);
    op1("slt", ALU_SLT, 32'hFFFF_FFFF, 32'h1, 32'd1);
    op1("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 32'd0);
    op1("undef_add", 4'b0101, 32'd3, 32'd4, 32'd7);
    op1("and", ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
    op1("or", ALU_OR, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0);
    op1("xor", ALU_XOR, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0);
    op1("srl0", ALU_SRL, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF);
    op1("sll0", ALU_SLL, 32'h1234_5678, 32'h0, 32'h1234_5678);

    shop("sra31", ALU_SRA, 32'h8000_0000, 32'd31, 8, 32'hFFFF_FFFF);
    shop("sll4", ALU_SLL, 32'h1, 32'd4, 1, 32'h10);
    shop("srl5", ALU_SRL, 32'hF000_0000, 32'd5, 2, 32'h0780_0000);
    shop("sra31p", ALU_SRA, 32'h7FFF_FFFF, 32'd31, 8, 32'h0);
    @(negedge clk);

    drive(ALU_ADD, 32'd1, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("b2b_vld", 32'(out_valid), 32'd1);
      check("b2b_res", result, 32'(2 * i));
      check("b2b_rdy", 32'(in_ready), 32'd1);
      if (i < 4) drive(ALU_ADD, 32'(i + 1), 32'(i + 1));
      else in_valid = 1'b0;
    end

    out_ready = 1'b0;
    drive(ALU_ADD, 32'd10, 32'd20);
    for (int j = 0; j < 3; j++) begin
      #1;
      check("bp_rdy", 32'(in_ready), 32'd0);
      check("bp_vld", 32'(out_valid), 32'd1);
      check("bp_res", result, 32'd8);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_rdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_next_vld", 32'(out_valid), 32'd1);
    check("bp_next_res", result, 32'd30);
    @(negedge clk);
    check("bp_drained", 32'(out_valid), 32'd0);

    drive(ALU_SLL, 32'h1, 32'd20);
    @(negedge clk);
    in_valid = 1'b0;
    check("fl_shift1_vld", 32'(out_valid), 32'd0);
    @(negedge clk);
    flush = 1'b1;
    drive(ALU_ADD, 32'd2, 32'd3);
    #1;
    check("fl_rdy", 32'(in_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("fl_post_vld", 32'(out_valid), 32'd0);
    check("fl_post_rdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("fl_add_vld", 32'(out_valid), 32'd1);
    check("fl_add_res", result, 32'd5);
    @(negedge clk);
    check("fl_add_drain", 32'(out_valid), 32'd0);

    drive(ALU_SRA, 32'h8000_0000, 32'd31);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_vld", 32'(out_valid), 32'd0);
    check("arst_res", result, 32'd0);
    check("arst_zero", 32'(zero), 32'd0);
    check("arst_rdy", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_rel_rdy", 32'(in_ready), 32'd1);
    check("arst_rel_vld", 32'(out_valid), 32'd0);
    op1("post_rst_add", ALU_ADD, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
